// File: rtl/decoder_pkg.sv
// Shared definitions for the registered 3-to-8 one-hot decoder.
//   CODE_W        : width of a binary input code
//   ONEHOT_W      : width of the decoded one-hot word
//   fifo_state_t  : occupancy state of the code buffer
//   decode()      : binary code -> one-hot word
package decoder_pkg;

  localparam int unsigned CODE_W   = 3;
  localparam int unsigned ONEHOT_W = 8;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } fifo_state_t;

  function automatic logic [ONEHOT_W-1:0] decode(input logic [CODE_W-1:0] code);
    decode = ONEHOT_W'(1) << code;
  endfunction

endpackage

// File: rtl/code_fifo.sv
// Small synchronous FIFO holding binary codes for decoder_3x8_pipe.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   wr_en     : store wr_data at the write pointer (caller guarantees !full)
//   wr_data   : code to store
//   rd_en     : advance the read pointer (caller guarantees !empty)
//   rd_data   : code at the head of the FIFO (stored state only)
//   full      : DEPTH codes buffered
//   empty     : no codes buffered
module code_fifo
  import decoder_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CODE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [CODE_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);

endmodule

// File: rtl/decoder_3x8_pipe.sv
// Registered 3-to-8 one-hot decoder with valid/ready on both sides.
// Codes are buffered in code_fifo; Y is decoded from the FIFO head, so
// there is no combinational path from In to Y.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   en         : input-side enable; low stalls intake, output still drains
//   In         : 3-bit binary code, in_valid/in_ready handshake
//   Y          : one-hot of head code, 8'h00 when out_valid is low
//   out_valid  : Y holds a word; out_ready takes it
//   out_cnt    : words delivered, modulo 2^CNT_W
// Optional build macro PARITY_CHECK_EN adds In_par (even parity over
// {In_par, In}) and sticky par_err; bad-parity words are consumed but
// not stored.
module decoder_3x8_pipe
  import decoder_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CODE_W-1:0]   In,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [ONEHOT_W-1:0] Y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    out_cnt
`ifdef PARITY_CHECK_EN
  ,
  input  logic                In_par,
  output logic                par_err
`endif
);

  fifo_state_t       w_state;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_store;
  logic              w_pop;
  logic [CODE_W-1:0] w_head;
  logic [CNT_W-1:0]  r_out_cnt;

  always_comb begin
    w_state = PARTIAL;
    if (w_empty) begin
      w_state = EMPTY;
    end else if (w_full) begin
      w_state = FULL;
    end
  end

  // in_ready ignores out_ready: a full buffer never lets a word slip through.
  assign in_ready  = en & ~rst & (w_state != FULL);
  assign out_valid = (w_state != EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

`ifdef PARITY_CHECK_EN
  logic w_par_ok;
  logic r_par_err;

  assign w_par_ok = ~(^{In_par, In});
  assign w_store  = w_push & w_par_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else if (w_push && !w_par_ok) begin
      r_par_err <= 1'b1;
    end
  end

  assign par_err = r_par_err;
`else
  assign w_store = w_push;
`endif

  code_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_store),
    .wr_data (In),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_cnt <= '0;
    end else if (w_pop) begin
      r_out_cnt <= r_out_cnt + 1'b1;
    end
  end

  assign out_cnt = r_out_cnt;
  assign Y       = out_valid ? decode(w_head) : '0;

endmodule

// File: tb/tb_decoder_3x8_pipe.sv
module tb_decoder_3x8_pipe;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] In = '0;
  logic       in_ready;
  logic [7:0] Y;
  logic       out_valid;
  logic [7:0] out_cnt;

`ifdef PARITY_CHECK_EN
  logic In_par = 1'b0;
  logic par_err;
  bit   bad_par = 1'b0;
  bit   m_perr = 1'b0;
`endif

  decoder_3x8_pipe #(
    .DEPTH (DEPTH),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .In        (In),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt)
`ifdef PARITY_CHECK_EN
    ,
    .In_par    (In_par),
    .par_err   (par_err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a queue of buffered codes plus a delivered-word counter.
  int         q[$];
  logic [7:0] m_cnt = '0;

  typedef struct {
    logic       r, e, iv;
    logic [2:0] c;
    logic       ordy;
    logic [7:0] y;
    logic       ov, ir;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [7:0] ey;
    logic       eov;
    eov = (q.size() != 0);
    ey  = eov ? (8'h01 << q[0]) : 8'h00;
    chk("model_y", {24'h0, Y}, {24'h0, ey});
    chk("model_out_valid", {31'h0, out_valid}, {31'h0, eov});
    chk("model_in_ready", {31'h0, in_ready}, {31'h0, (en && !rst && q.size() < DEPTH)});
    chk("model_out_cnt", {24'h0, out_cnt}, {24'h0, m_cnt});
    chk("y_onehot_or_zero", {31'h0, ($countones(Y) <= 1)}, 32'h1);
`ifdef PARITY_CHECK_EN
    chk("model_par_err", {31'h0, par_err}, {31'h0, m_perr});
`endif
  endtask

  // Drive one cycle of inputs, step the model across the edge, then compare.
  task automatic tick(input logic r, input logic e, input logic iv,
                      input logic [2:0] c, input logic ordy);
    bit push, pop, store;
    rst = r; en = e; in_valid = iv; In = c; out_ready = ordy;
    push  = iv && e && !r && (q.size() < DEPTH);
    pop   = (q.size() != 0) && ordy;
    store = push;
`ifdef PARITY_CHECK_EN
    In_par = bad_par ? ~(^c) : (^c);
    store  = push && !bad_par;
`endif
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_cnt = '0;
`ifdef PARITY_CHECK_EN
      m_perr = 1'b0;
`endif
    end else begin
      if (pop) begin
        void'(q.pop_front());
        m_cnt++;
      end
      if (store) q.push_back(int'(c));
`ifdef PARITY_CHECK_EN
      if (push && bad_par) m_perr = 1'b1;
`endif
    end
    check_model();
  endtask

  task automatic expect_out(input string name, input logic [7:0] y, input logic ov,
                            input logic ir, input logic [7:0] cnt);
    chk({name, "_y"}, {24'h0, Y}, {24'h0, y});
    chk({name, "_out_valid"}, {31'h0, out_valid}, {31'h0, ov});
    chk({name, "_in_ready"}, {31'h0, in_ready}, {31'h0, ir});
    chk({name, "_out_cnt"}, {24'h0, out_cnt}, {24'h0, cnt});
  endtask

  initial begin
    vec_t v;
    int   codes[4];

    // Reset, idle with en low, then the 0..7 sweep with the consumer always ready.
    tbl.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0});
    for (int k = 0; k < 8; k++) begin
      v = '{1'b0, 1'b1, 1'b1, 3'(k), 1'b1, 8'h01 << k, 1'b1, 1'b1, 8'(k)};
      tbl.push_back(v);
    end
    tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 8'd8});

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].r, tbl[i].e, tbl[i].iv, tbl[i].c, tbl[i].ordy);
      expect_out($sformatf("vec%0d", i), tbl[i].y, tbl[i].ov, tbl[i].ir, tbl[i].cnt);
    end

    // Backpressure: fill to FULL, a blocked offer is not taken, then drain.
    tick(1'b0, 1'b1, 1'b1, 3'b101, 1'b0); expect_out("bp_push1", 8'h20, 1'b1, 1'b1, 8'd8);
    tick(1'b0, 1'b1, 1'b1, 3'b010, 1'b0); expect_out("bp_full", 8'h20, 1'b1, 1'b0, 8'd8);
    tick(1'b0, 1'b1, 1'b1, 3'b111, 1'b0); expect_out("bp_blocked", 8'h20, 1'b1, 1'b0, 8'd8);
    tick(1'b0, 1'b1, 1'b0, 3'b000, 1'b1); expect_out("bp_pop1", 8'h04, 1'b1, 1'b1, 8'd9);
    tick(1'b0, 1'b1, 1'b0, 3'b000, 1'b1); expect_out("bp_pop2", 8'h00, 1'b0, 1'b1, 8'd10);

    // Simultaneous push and pop with one word buffered: occupancy stays 1.
    tick(1'b0, 1'b1, 1'b1, 3'd6, 1'b0); expect_out("pp_seed", 8'h40, 1'b1, 1'b1, 8'd10);
    codes = '{1, 3, 0, 7};
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 1'b1, 3'(codes[i]), 1'b1);
      expect_out($sformatf("pp%0d", i), 8'h01 << codes[i], 1'b1, 1'b1, 8'(11 + i));
    end
    tick(1'b0, 1'b1, 1'b0, 3'd0, 1'b1); expect_out("pp_drain", 8'h00, 1'b0, 1'b1, 8'd15);

    // en low: intake stalls while the output side still drains.
    tick(1'b0, 1'b1, 1'b1, 3'd4, 1'b0); expect_out("en_seed", 8'h10, 1'b1, 1'b1, 8'd15);
    tick(1'b0, 1'b0, 1'b1, 3'd3, 1'b1); expect_out("en_low", 8'h00, 1'b0, 1'b0, 8'd16);

    // Reset while FULL discards everything; intake resumes afterwards.
    tick(1'b0, 1'b1, 1'b1, 3'd1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 3'd2, 1'b0); expect_out("rst_full", 8'h02, 1'b1, 1'b0, 8'd16);
    tick(1'b1, 1'b1, 1'b1, 3'd3, 1'b0); expect_out("rst_mid", 8'h00, 1'b0, 1'b0, 8'd0);
    tick(1'b0, 1'b1, 1'b1, 3'b011, 1'b0); expect_out("rst_resume", 8'h08, 1'b1, 1'b1, 8'd0);
    tick(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);

`ifdef PARITY_CHECK_EN
    bad_par = 1'b1;
    tick(1'b0, 1'b1, 1'b1, 3'b001, 1'b0);
    expect_out("par_bad", 8'h00, 1'b0, 1'b1, 8'd1);
    chk("par_bad_err", {31'h0, par_err}, 32'h1);
    bad_par = 1'b0;
    tick(1'b0, 1'b1, 1'b1, 3'b011, 1'b0);
    expect_out("par_good", 8'h08, 1'b1, 1'b1, 8'd1);
    chk("par_sticky", {31'h0, par_err}, 32'h1);
    tick(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
`endif

    // Randomized traffic against the queue model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
`ifdef PARITY_CHECK_EN
      bad_par = ($urandom_range(0, 15) == 0);
`endif
      tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom), 3'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_3x8_pipe.md
Name: decoder_3x8_pipe

Overview:
- Registered 3-to-8 one-hot decoder with valid/ready flow control on both sides.
- It is the inverse of the team's 8x3 encoder. It accepts 3-bit binary codes, buffers them in a small FIFO, and presents each code as an 8-bit one-hot word on Y.
- It sits between a code producer (for example, the encoder path) and a one-hot consumer (select lines, LED or demux banks).
- There is no combinational path from In to Y.

Parameters:
- DEPTH, 2, number of buffered codes. Must be a power of 2 and at least 2.
- CNT_W, 8, width of the delivered-word counter out_cnt.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  input-side enable. When low, no new codes are accepted.
- In  input  3  binary code to decode.
- in_valid  input  1  In is valid this cycle.
- in_ready  output  1  block can accept In this cycle.
- Y  output  8  one-hot decode of the head code. Equals 8'h00 when out_valid is 0.
- out_valid  output  1  Y holds a valid word.
- out_ready  input  1  consumer takes Y this cycle.
- out_cnt  output  CNT_W  number of words delivered, modulo 2^CNT_W.

Behaviour:
- Reset values (rst sampled high at a clk edge): count=0, read/write pointers=0, out_valid=0, Y=8'h00, out_cnt=0. in_ready is forced to 0 while rst is high.
- in_ready = en & ~rst & (count < DEPTH). This is combinational from registered state and en only. It does not depend on out_ready, so a word can never pass straight through when the FIFO is full.
- Push occurs when in_valid & in_ready at a clk edge. In is written at the write pointer.
- Pop occurs when out_valid & out_ready at a clk edge. On a pop, out_cnt increments and wraps from 2^CNT_W-1 to 0.
- out_valid = (count != 0).
- Y = (8'b1 << head_code) when out_valid is 1, otherwise 8'h00. Y is driven from stored state only.
- Latency: a code pushed at edge N appears on Y/out_valid immediately after edge N, if the FIFO was empty.
- State machine, derived from count:
  - EMPTY: count=0.
  - PARTIAL: 0 < count < DEPTH.
  - FULL: count=DEPTH.
- Transitions:
  - EMPTY + push -> PARTIAL.
  - PARTIAL + push only -> PARTIAL or FULL.
  - PARTIAL + pop only -> PARTIAL or EMPTY.
  - PARTIAL + push and pop -> unchanged count; the head advances and the new code is written.
  - FULL + pop -> PARTIAL. A push is impossible in FULL because in_ready=0.
  - EMPTY + pop is impossible because out_valid=0.
- Pointers are log2(DEPTH) bits wide and wrap naturally.
- out_ready asserted while out_valid=0 has no effect.
- in_valid asserted while in_ready=0: the word is not taken. The producer must hold In stable until the handshake completes.
- en deasserted: input is stalled, but the output side keeps draining. en has no effect on Y except through starvation.
- Y must always be exactly one-hot or all-zero. Code 3'b000 decodes to 8'b00000001 and code 3'b111 decodes to 8'b10000000.
- Reset mid-operation: all buffered codes are discarded. On the cycle after the reset edge, out_valid=0 and Y=0.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- When defined:
  - Adds input In_par (1 bit) and output par_err (1 bit, reset 0).
  - A push requires even parity: ^{In_par, In} == 0.
  - On a mismatch the handshake still completes (the word is consumed), but the word is not stored and out_cnt is unaffected.
  - par_err is set and stays sticky until rst.
- When undefined: In_par and par_err do not exist, and every push is stored.

Decomposition:
- Package decoder_pkg holds:
  - CODE_W=3 and ONEHOT_W=8.
  - The state typedef {EMPTY, PARTIAL, FULL}.
  - A decode function (code -> one-hot).
- One sub-module, code_fifo. It provides DEPTH x CODE_W storage, pointers, count, and full/empty flags. The top level adds en gating, decode, out_cnt and the parity check.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then release with en=0 and in_valid=1 -> in_ready=0, out_valid=0, Y=8'h00, out_cnt=0.
- Sweep: en=1, out_ready=1, push codes 0..7 on consecutive cycles -> Y=01,02,04,08,10,20,40,80 each one cycle after its push; out_cnt=8.
- Backpressure: out_ready=0, push 3'b101 then 3'b010 -> FULL, in_ready=0, Y=8'h20 held. Raise out_ready -> Y=8'h04 next cycle, then 8'h00.
- Simultaneous push and pop in PARTIAL: count stays 1 across 4 cycles and Y tracks each new code with 1-cycle lag.
- Reset mid-stream: FIFO FULL, assert rst for one cycle -> next cycle out_valid=0, Y=0, out_cnt=0. Resume push 3'b011 -> Y=8'h08.
- PARITY_CHECK_EN: push In=3'b001 with In_par=0 -> no store, par_err=1. Then push In=3'b011 with In_par=0 -> Y=8'h08 and par_err remains 1.
